// File: rtl/spi_reg_ctrl.sv
// rtl/spi_reg_ctrl.sv - SPI command byte stream to register-file access controller
//
// Purpose:
//   Synchronises the SPI slave's byte-ready flag and chip-select into the
//   sysclk domain and decodes each CS frame. The first byte of a frame is a
//   command: bit7 selects read (1) or write (0), and bits[6:0] give the
//   register address. Write frames issue single-cycle register writes. Read
//   frames issue a register read and load the returned data into the slave's
//   transmit path. A frame that is aborted is counted in a saturating
//   error counter.
//
// Build option:
//   SPI_REG_AUTOINC_EN - when defined, write and read frames burst with a
//   7-bit wrapping address auto-increment. When it is undefined, only one
//   access is made per frame and any further bytes are drained.
//
// Parameters:
//   TIMEOUT     - sysclk cycles without a byte (CS low) before a frame aborts
//   SYNC_STAGES - synchroniser depth on iRxReady / iSPICS (2..3)
//
// Ports:
//   sysclk     in   system clock
//   iRstN      in   asynchronous active-low reset
//   iRxReady   in   byte-ready level from the SPI slave (async)
//   iRx[7:0]   in   received byte, stable from iRxReady rise
//   iSPICS     in   chip select, active-low (async)
//   oTxReady   out  1-cycle pulse, oTx valid for loading into the slave
//   oTx[7:0]   out  byte to shift out on MISO
//   oRegAddr   out  register address [6:0]
//   oRegWData  out  register write data [7:0]
//   oRegWe     out  1-cycle register write strobe
//   oRegRe     out  1-cycle register read strobe
//   iRegRData  in   register read data, valid the cycle after oRegRe
//   oErrCount  out  saturating count of aborted frames [7:0]

module spi_reg_ctrl #(
   parameter logic [15:0] TIMEOUT     = 16'd50000,
   parameter int          SYNC_STAGES = 2
) (
   input  logic       sysclk,
   input  logic       iRstN,
   input  logic       iRxReady,
   input  logic [7:0] iRx,
   input  logic       iSPICS,
   output logic       oTxReady,
   output logic [7:0] oTx,
   output logic [6:0] oRegAddr,
   output logic [7:0] oRegWData,
   output logic       oRegWe,
   output logic       oRegRe,
   input  logic [7:0] iRegRData,
   output logic [7:0] oErrCount
);

`ifdef SPI_REG_AUTOINC_EN
   localparam logic AUTOINC = 1'b1;
`else
   localparam logic AUTOINC = 1'b0;
`endif

   typedef enum logic [2:0] {
      S_IDLE,
      S_CMD,
      S_WR,
      S_RD_ISSUE,
      S_RD_LOAD,
      S_RD,
      S_DRAIN
   } state_t;

   // Synchroniser and strobe generation
   logic [SYNC_STAGES-1:0] rx_sync_q, rx_sync_d;
   logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
   logic                   rx_prev_q, rx_prev_d;
   logic                   strobe_q, strobe_d;
   logic [7:0]             byte_q, byte_d;

   // Frame state and register-side outputs
   state_t      state_q, state_d;
   logic [6:0]  addr_q, addr_d;
   logic [7:0]  wdata_q, wdata_d;
   logic        we_q, we_d;
   logic        re_q, re_d;
   logic        txr_q, txr_d;
   logic [7:0]  tx_q, tx_d;
   logic [7:0]  err_q, err_d;
   logic [15:0] tmo_q, tmo_d;
   logic        wr_done_q, wr_done_d;

   logic rx_rise;
   logic cs_high;
   logic tmo_hit;
   logic err_inc;

   always_comb begin
      rx_sync_d = {rx_sync_q[SYNC_STAGES-2:0], iRxReady};
      cs_sync_d = {cs_sync_q[SYNC_STAGES-2:0], iSPICS};
      rx_prev_d = rx_sync_q[SYNC_STAGES-1];
      rx_rise   = rx_sync_q[SYNC_STAGES-1] & ~rx_prev_q;
      // The strobe is registered and the byte is captured on the same edge,
      // so byte_q is already valid in the cycle the FSM sees strobe_q.
      strobe_d  = rx_rise;
      byte_d    = rx_rise ? iRx : byte_q;
   end

   always_comb begin
      cs_high   = cs_sync_q[SYNC_STAGES-1];
      tmo_hit   = (tmo_q == (TIMEOUT - 16'd1));

      state_d   = state_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      we_d      = 1'b0;
      re_d      = 1'b0;
      txr_d     = 1'b0;
      tmo_d     = tmo_q;
      wr_done_d = wr_done_q;
      err_inc   = 1'b0;

      // The load pulse passes read data straight through (see oTx below);
      // keep a copy so oTx holds it until the next load.
      tx_d      = txr_q ? iRegRData : tx_q;

      // Burst writes advance the address only after the write cycle, so
      // oRegAddr is correct while oRegWe is high.
      if (we_q && AUTOINC) begin
         addr_d = addr_q + 7'd1;
      end

      if (state_q == S_IDLE) begin
         if (!cs_high) begin
            state_d   = S_CMD;
            tmo_d     = 16'd0;
            wr_done_d = 1'b0;
         end
      end else if (cs_high) begin
         // CS takes priority over a strobe in the same cycle: byte dropped.
         state_d = S_IDLE;
         if ((state_q == S_CMD) || ((state_q == S_WR) && !wr_done_q)) begin
            err_inc = 1'b1;
         end
      end else if (state_q != S_DRAIN) begin
         tmo_d = strobe_q ? 16'd0 : (tmo_q + 16'd1);

         unique case (state_q)
            S_CMD: begin
               if (strobe_q) begin
                  addr_d  = byte_q[6:0];
                  state_d = byte_q[7] ? S_RD_ISSUE : S_WR;
               end
            end
            S_WR: begin
               if (strobe_q) begin
                  wdata_d   = byte_q;
                  we_d      = 1'b1;
                  wr_done_d = 1'b1;
                  if (!AUTOINC) begin
                     state_d = S_DRAIN;
                  end
               end
            end
            S_RD_ISSUE: begin
               re_d    = 1'b1;
               state_d = S_RD_LOAD;
            end
            S_RD_LOAD: begin
               txr_d   = 1'b1;
               state_d = S_RD;
            end
            S_RD: begin
               if (strobe_q) begin
                  if (AUTOINC) begin
                     addr_d  = addr_q + 7'd1;
                     state_d = S_RD_ISSUE;
                  end else begin
                     state_d = S_DRAIN;
                  end
               end
            end
            default: begin
            end
         endcase

         // A strobe arriving in the timeout cycle keeps the frame alive.
         if (!strobe_q && tmo_hit) begin
            state_d = S_DRAIN;
            re_d    = 1'b0;
            txr_d   = 1'b0;
            err_inc = 1'b1;
         end
      end

      err_d = (err_inc && (err_q != 8'hFF)) ? (err_q + 8'd1) : err_q;
   end

   always_ff @(posedge sysclk or negedge iRstN) begin
      if (!iRstN) begin
         rx_sync_q <= '0;
         cs_sync_q <= '1;
         rx_prev_q <= 1'b0;
         strobe_q  <= 1'b0;
         byte_q    <= 8'h00;
         state_q   <= S_IDLE;
         addr_q    <= 7'h00;
         wdata_q   <= 8'h00;
         we_q      <= 1'b0;
         re_q      <= 1'b0;
         txr_q     <= 1'b0;
         tx_q      <= 8'h00;
         err_q     <= 8'h00;
         tmo_q     <= 16'd0;
         wr_done_q <= 1'b0;
      end else begin
         rx_sync_q <= rx_sync_d;
         cs_sync_q <= cs_sync_d;
         rx_prev_q <= rx_prev_d;
         strobe_q  <= strobe_d;
         byte_q    <= byte_d;
         state_q   <= state_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         we_q      <= we_d;
         re_q      <= re_d;
         txr_q     <= txr_d;
         tx_q      <= tx_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
         wr_done_q <= wr_done_d;
      end
   end

   assign oRegAddr  = addr_q;
   assign oRegWData = wdata_q;
   assign oRegWe    = we_q;
   assign oRegRe    = re_q;
   assign oTxReady  = txr_q;
   // Read data arrives in the same cycle as the load pulse, so it is passed
   // through during the pulse and held from tx_q afterwards.
   assign oTx       = txr_q ? iRegRData : tx_q;
   assign oErrCount = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// tb/tb_spi_reg_ctrl.sv - randomized self-checking bench for spi_reg_ctrl
module tb_spi_reg_ctrl;

   localparam int          SYNC = 2;
   localparam logic [15:0] TMO  = 16'd400;
`ifdef SPI_REG_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   logic       sysclk   = 1'b0;
   logic       iRstN    = 1'b0;
   logic       iRxReady = 1'b0;
   logic [7:0] iRx      = 8'h00;
   logic       iSPICS   = 1'b1;
   logic       oTxReady;
   logic [7:0] oTx;
   logic [6:0] oRegAddr;
   logic [7:0] oRegWData;
   logic       oRegWe;
   logic       oRegRe;
   logic [7:0] iRegRData = 8'h00;
   logic [7:0] oErrCount;

   spi_reg_ctrl #(.TIMEOUT(TMO), .SYNC_STAGES(SYNC)) dut (
      .sysclk   (sysclk),
      .iRstN    (iRstN),
      .iRxReady (iRxReady),
      .iRx      (iRx),
      .iSPICS   (iSPICS),
      .oTxReady (oTxReady),
      .oTx      (oTx),
      .oRegAddr (oRegAddr),
      .oRegWData(oRegWData),
      .oRegWe   (oRegWe),
      .oRegRe   (oRegRe),
      .iRegRData(iRegRData),
      .oErrCount(oErrCount)
   );

   always #5 sysclk = ~sysclk;

   int cyc = 0;
   always @(posedge sysclk) cyc <= cyc + 1;

   // Register file the controller talks to
   logic [7:0] mem [128];
   always @(posedge sysclk) begin
      if (oRegWe) mem[oRegAddr] <= oRegWData;
      if (oRegRe) iRegRData <= mem[oRegAddr];
   end

   // Observed activity
   logic [14:0] wr_got[$];
   logic [6:0]  re_got[$];
   logic [7:0]  tx_got[$];
   int          we_cyc[$], re_cyc[$], tx_cyc[$], rise_t[$];

   always @(negedge sysclk) begin
      if (iRstN) begin
         if (oRegWe)   begin wr_got.push_back({oRegAddr, oRegWData}); we_cyc.push_back(cyc); end
         if (oRegRe)   begin re_got.push_back(oRegAddr); re_cyc.push_back(cyc); end
         if (oTxReady) begin tx_got.push_back(oTx); tx_cyc.push_back(cyc); end
      end
   end

   // Reference model state
   logic [7:0]  mdl_mem [128];
   logic [7:0]  exp_err = 8'h00;
   logic [14:0] exp_wr[$];
   logic [6:0]  exp_ra[$];
   logic [7:0]  exp_rd[$];
   logic [7:0]  fb [8];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

   task automatic clear_obs();
      wr_got.delete(); re_got.delete(); tx_got.delete();
      we_cyc.delete(); re_cyc.delete(); tx_cyc.delete(); rise_t.delete();
      exp_wr.delete(); exp_ra.delete(); exp_rd.delete();
   endtask

   task automatic send_byte(input logic [7:0] b);
      @(posedge sysclk); #1;
      iRx = b;
      rise_t.push_back(cyc);
      iRxReady = 1'b1;
      repeat (4) @(posedge sysclk);
      #1 iRxReady = 1'b0;
      repeat (8) @(posedge sysclk);
   endtask

   task automatic cs_low();
      @(posedge sysclk); #1 iSPICS = 1'b0;
      repeat (5) @(posedge sysclk);
   endtask

   task automatic cs_high();
      @(posedge sysclk); #1 iSPICS = 1'b1;
      repeat (5) @(posedge sysclk);
   endtask

   // One CS frame of n bytes from fb[], with expectations from the frame rules
   task automatic run_frame(input int n);
      logic [6:0] a;
      int nr;
      clear_obs();
      if (n == 0 || (n == 1 && !fb[0][7])) exp_err = sat_inc(exp_err);
      if (n >= 1) begin
         a = fb[0][6:0];
         if (!fb[0][7]) begin
            for (int i = 1; i < n; i++) begin
               if (AUTOINC || i == 1) begin
                  exp_wr.push_back({a, fb[i]});
                  mdl_mem[a] = fb[i];
                  a = a + 7'd1;
               end
            end
         end else begin
            nr = AUTOINC ? n : 1;
            for (int i = 0; i < nr; i++) begin
               exp_ra.push_back(a);
               exp_rd.push_back(mdl_mem[a]);
               a = a + 7'd1;
            end
         end
      end
      cs_low();
      for (int i = 0; i < n; i++) send_byte(fb[i]);
      cs_high();
      check("wr_count", wr_got.size(), exp_wr.size());
      for (int i = 0; i < exp_wr.size() && i < wr_got.size(); i++) begin
         check("wr_addr_data", wr_got[i], exp_wr[i]);
         check("wr_latency", we_cyc[i] - rise_t[i+1], SYNC + 2);
      end
      check("rd_count", re_got.size(), exp_ra.size());
      check("tx_count", tx_got.size(), exp_rd.size());
      for (int i = 0; i < exp_ra.size() && i < re_got.size() && i < tx_got.size(); i++) begin
         check("rd_addr", re_got[i], exp_ra[i]);
         check("rd_latency", re_cyc[i] - rise_t[i], SYNC + 3);
         check("tx_data", tx_got[i], exp_rd[i]);
         check("tx_latency", tx_cyc[i] - rise_t[i], SYNC + 4);
      end
      check("err_count", oErrCount, exp_err);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_we"}, oRegWe, 1'b0);
      check({tag, "_re"}, oRegRe, 1'b0);
      check({tag, "_txr"}, oTxReady, 1'b0);
      check({tag, "_tx"}, oTx, 8'h00);
      check({tag, "_addr"}, oRegAddr, 7'h00);
      check({tag, "_wdata"}, oRegWData, 8'h00);
      check({tag, "_err"}, oErrCount, 8'h00);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1);
   end

   initial begin
      for (int i = 0; i < 128; i++) begin
         mem[i]     = 8'($urandom);
         mdl_mem[i] = mem[i];
      end

      // Reset state
      repeat (3) @(posedge sysclk);
      #1 check_reset_outputs("reset");
      iRstN = 1'b1;
      repeat (3) @(posedge sysclk);

      // An aborted frame, then a reset mid-frame clears everything
      run_frame(0);
      cs_low();
      send_byte(8'h05);
      #1 iRstN = 1'b0;
      #1 check_reset_outputs("midreset");
      iSPICS = 1'b1;
      exp_err = 8'h00;
      repeat (3) @(posedge sysclk);
      #1 iRstN = 1'b1;
      repeat (3) @(posedge sysclk);
      fb[0] = 8'h05; fb[1] = 8'hA5;
      run_frame(2);

      // Read of address 3
      mem[3] = 8'h3C; mdl_mem[3] = 8'h3C;
      fb[0] = 8'h83;
      run_frame(1);

      // Burst write across the address wrap
      fb[0] = 8'h7F; fb[1] = 8'h11; fb[2] = 8'h22; fb[3] = 8'h33;
      run_frame(4);

      // CS rises after the command byte only
      fb[0] = 8'h10;
      run_frame(1);
      check("early_cs_err", oErrCount, 8'h01);

      // CS rises together with the data byte
      clear_obs();
      cs_low();
      send_byte(8'h10);
      @(posedge sysclk); #1;
      iRx = 8'h99; iRxReady = 1'b1; iSPICS = 1'b1;
      repeat (4) @(posedge sysclk);
      #1 iRxReady = 1'b0;
      repeat (10) @(posedge sysclk);
      exp_err = sat_inc(exp_err);
      check("coincident_wr_count", wr_got.size(), 0);
      check("coincident_err", oErrCount, 8'h02);

      // Timeout after the command byte, later bytes ignored
      clear_obs();
      cs_low();
      send_byte(8'h20);
      repeat (int'(TMO) + 20) @(posedge sysclk);
      exp_err = sat_inc(exp_err);
      #1 check("timeout_err", oErrCount, exp_err);
      send_byte(8'h77);
      send_byte(8'h78);
      cs_high();
      check("timeout_wr_count", wr_got.size(), 0);
      check("timeout_err_after_cs", oErrCount, exp_err);

      // Random frames
      for (int f = 0; f < 40; f++) begin
         int n;
         n = $urandom_range(0, 4);
         for (int i = 0; i < 8; i++) fb[i] = 8'($urandom);
         if ($urandom_range(0, 3) == 0) fb[0][6:0] = 7'h7E | 7'($urandom_range(0, 1));
         run_frame(n);
      end

      // Saturation of the error counter
      for (int f = 0; f < 300; f++) begin
         cs_low();
         cs_high();
         exp_err = sat_inc(exp_err);
      end
      check("err_saturated", oErrCount, 8'hFF);
      check("err_model_sat", oErrCount, exp_err);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/spi_reg_ctrl.md
# spi_reg_ctrl

Command/register controller sitting behind the SPI slave byte engine in the pifan FPGA. It turns the received byte stream into register-file accesses: it synchronises the slave's byte-ready flag and chip-select into the `sysclk` domain, then decodes a command byte and issues single-cycle register writes or reads. Read data is loaded back into the slave's transmit path. Fan-control registers connect on the register side; the Raspberry Pi is the SPI master.

## Interface
- `TIMEOUT`, 16'd50000: `sysclk` cycles without a byte, while CS is low, before the frame is aborted.
- `SYNC_STAGES`, 2: flop stages on `iRxReady` and `iSPICS` (legal 2..3).
- `sysclk` input 1: system clock. One clock domain for all logic.
- `iRstN` input 1: reset, asynchronous, active-low.
- `iRxReady` input 1: byte-ready flag from the SPI slave (SPI clock domain, level).
- `iRx` input 8: received byte. Stable from the `iRxReady` rise until the next byte completes.
- `iSPICS` input 1: chip select, active-low (asynchronous).
- `oTxReady` output 1: 1-cycle pulse; `oTx` is valid to load into the slave.
- `oTx` output 8: byte for the slave to shift out on MISO.
- `oRegAddr` output 7: register address.
- `oRegWData` output 8: write data.
- `oRegWe` output 1: 1-cycle write strobe.
- `oRegRe` output 1: 1-cycle read strobe.
- `iRegRData` input 8: read data, valid the cycle after `oRegRe`.
- `oErrCount` output 8: saturating count of aborted frames.

## Operation
- **Synchronisation**
  - `iRxReady` and `iSPICS` each pass through `SYNC_STAGES` flops.
  - `strobe` is the rising edge of synced `iRxReady`.
  - `iRx` is captured into `byteReg` on `strobe`.
- **Frame format**
  - Byte 0 is CMD: bit7 = 1 means read, 0 means write; bits[6:0] are the address.
  - Subsequent bytes are data (write) or dummy (read).
- **States:** IDLE, CMD, WR, RD_ISSUE, RD_LOAD, RD, DRAIN.
  - **IDLE:** wait for synced CS low, then go to CMD and clear the timeout counter.
  - **CMD:** on `strobe`, latch address = `byteReg[6:0]`.
    - bit7 = 0: go to WR.
    - bit7 = 1: go to RD_ISSUE.
  - **WR:** on `strobe`, drive `oRegWData` = byte and pulse `oRegWe`.
    - Then address+1 and stay in WR (autoinc build), or go to DRAIN.
  - **RD_ISSUE:** pulse `oRegRe` for 1 cycle, then go to RD_LOAD.
  - **RD_LOAD:** `oTx` ← `iRegRData`, pulse `oTxReady`, then go to RD.
  - **RD:** on `strobe` (the master clocked out the byte):
    - autoinc build: address+1, then RD_ISSUE.
    - otherwise: DRAIN.
  - **DRAIN:** ignore strobes until CS high.
- **From any non-IDLE state**
  - Synced CS high → IDLE next cycle.
  - If the state was CMD with no byte, or WR with no data byte accepted, `oErrCount`++.
  - Timeout reached → DRAIN, `oErrCount`++.
- **Timeout counter:** counts while not IDLE and not DRAIN. Cleared on `strobe` and on entry to CMD.
- **Arithmetic**
  - Address increment is 7-bit and wraps 7'h7F → 7'h00.
  - `oErrCount` saturates at 8'hFF.
- **Simultaneous events**
  - CS high and `strobe` in the same cycle: CS wins, the byte is discarded, no `oRegWe`.
  - Timeout and `strobe` in the same cycle: `strobe` wins.
- **Reset:** all outputs 0, address 0, state IDLE, counters 0. Reset mid-frame returns the block to IDLE; the frame is lost and not counted.

## Timing
- Requirement: the SPI byte period must be ≥ `SYNC_STAGES` + 6 `sysclk` cycles.
- `strobe` occurs `SYNC_STAGES` + 1 cycles after `iRxReady` rises at the `sysclk` edge.
- Write: `oRegWe` is high in the cycle after the `strobe` that accepts the data byte, with `oRegAddr`/`oRegWData` valid in that cycle.
- Read: relative to the CMD `strobe` at cycle S:
  - `oRegRe` at S+2.
  - `oTxReady`/`oTx` at S+3.
  - Total read latency is 3 cycles from `strobe`.
- `oTx` holds its value until the next load; `oRegAddr`/`oRegWData` hold between strobes.

## Configuration
- `SPI_REG_AUTOINC_EN` defined:
  - WR and RD loop with address auto-increment, giving burst access within one CS frame.
- Undefined:
  - One data byte per frame; further bytes are ignored in DRAIN.
  - No `oRegWe`/`oRegRe` after the first access.

## Test plan
- **Reset:** `iRstN` low mid-frame → all outputs 0, IDLE; next frame CMD 8'h05 + data 8'hA5 → `oRegWe` once, `oRegAddr`=5, `oRegWData`=8'hA5.
- **Read:** CMD 8'h83, `iRegRData`=8'h3C → `oRegRe` at S+2 with addr 3; `oTxReady` at S+3 with `oTx`=8'h3C.
- **Burst write (with `SPI_REG_AUTOINC_EN`):** CMD 8'h7F, data 11, 22, 33 → writes to addresses 7F, 00, 01. Without the macro → a single write to 7F.
- **Early CS / simultaneous event:** CS rises after CMD 8'h10 only → no `oRegWe`, `oErrCount`=1. CS rise coincident with the data `strobe` → no write, `oErrCount`=2.
- **Timeout:** CS low, one CMD byte, then `TIMEOUT` idle cycles → DRAIN, `oErrCount`+1; later bytes are ignored until CS high.
- **Saturation:** 300 aborted frames → `oErrCount`=8'hFF.
